// File: rtl/arb_grant_buffer.sv
// arb_grant_buffer: captures one transaction per new one-hot arbiter grant,
// muxes the granted payload into a tagged FWFT FIFO drained by valid/ready.
// Optional per-source grant statistics are enabled by ARB_GRANT_BUF_STATS_EN.
module arb_grant_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [2:0]               g,
    input  logic [DATA_W-1:0]        d0,
    input  logic [DATA_W-1:0]        d1,
    input  logic [DATA_W-1:0]        d2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_src,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     grant_err
`ifdef ARB_GRANT_BUF_STATS_EN
    ,
    output logic [15:0]              gcnt0,
    output logic [15:0]              gcnt1,
    output logic [15:0]              gcnt2
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [2:0]        r_g_q;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_grant_err;
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [1:0]        r_mem_src  [DEPTH];

    logic [2:0]        w_rise;
    logic              w_g_multi;
    logic              w_rise_onehot;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_idx;
    logic [DATA_W-1:0] w_din;

    // A grant that was already high last cycle is not a new transaction; an
    // illegal multi-bit grant never pushes even if exactly one bit just rose.
    assign w_rise        = g & ~r_g_q;
    assign w_g_multi     = (g & (g - 3'd1)) != 3'd0;
    assign w_rise_onehot = (w_rise != 3'd0) && ((w_rise & (w_rise - 3'd1)) == 3'd0);
    assign w_push_req    = w_rise_onehot && !w_g_multi;
    assign w_pop         = out_valid && out_ready;
    assign w_push        = w_push_req && ((r_count != FULL_CNT) || w_pop);

    // Select source index and payload of the newly granted requester
    always_comb begin
        w_idx = 2'd0;
        w_din = d0;
        if (w_rise[1]) begin
            w_idx = 2'd1;
            w_din = d1;
        end else if (w_rise[2]) begin
            w_idx = 2'd2;
            w_din = d2;
        end
    end

    // Control state: grant history, pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_g_q       <= 3'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_g_q <= g;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            if (w_g_multi)
                r_grant_err <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care until covered by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_din;
            r_mem_src[r_wr_ptr]  <= w_idx;
        end
    end

    // Head is shown only while an entry exists, so an empty FIFO reads zero
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_src   = out_valid ? r_mem_src[r_rd_ptr]  : 2'd0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign grant_err = r_grant_err;

`ifdef ARB_GRANT_BUF_STATS_EN
    logic [15:0] r_gcnt0;
    logic [15:0] r_gcnt1;
    logic [15:0] r_gcnt2;

    // Saturating count of accepted pushes per source
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_gcnt0 <= 16'd0;
            r_gcnt1 <= 16'd0;
            r_gcnt2 <= 16'd0;
        end else if (w_push) begin
            if (w_idx == 2'd0 && r_gcnt0 != 16'hFFFF) r_gcnt0 <= r_gcnt0 + 16'd1;
            if (w_idx == 2'd1 && r_gcnt1 != 16'hFFFF) r_gcnt1 <= r_gcnt1 + 16'd1;
            if (w_idx == 2'd2 && r_gcnt2 != 16'hFFFF) r_gcnt2 <= r_gcnt2 + 16'd1;
        end
    end

    assign gcnt0 = r_gcnt0;
    assign gcnt1 = r_gcnt1;
    assign gcnt2 = r_gcnt2;
`endif
endmodule

// File: tb/tb_arb_grant_buffer.sv
// Testbench for arb_grant_buffer: directed vector table, hand sequences for
// latency and mid-operation reset, then randomized traffic against a queue model.
module tb_arb_grant_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [2:0]        g = 3'd0;
    logic [DATA_W-1:0] d0 = '0, d1 = '0, d2 = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic [2:0]        count;
    logic              overflow;
    logic              grant_err;
`ifdef ARB_GRANT_BUF_STATS_EN
    logic [15:0]       gcnt0, gcnt1, gcnt2;
`endif

    arb_grant_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .g(g), .d0(d0), .d1(d1), .d2(d2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .count(count), .overflow(overflow), .grant_err(grant_err)
`ifdef ARB_GRANT_BUF_STATS_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1), .gcnt2(gcnt2)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: inputs applied before an edge, expectations after it
    typedef struct {
        logic        rstn;
        logic [2:0]  gv;
        logic [7:0]  a, b, c;
        logic        rdy;
        int          cnt;
        logic        vld;
        logic [7:0]  dat;
        logic [1:0]  src;
        logic        ovf;
        logic        gerr;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rstn, input logic [2:0] gv, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic rdy,
                        input int cnt, input logic vld, input logic [7:0] dat,
                        input logic [1:0] src, input logic ovf, input logic gerr);
        vec_t v;
        v.rstn = rstn; v.gv = gv; v.a = a; v.b = b; v.c = c; v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.dat = dat; v.src = src; v.ovf = ovf; v.gerr = gerr;
        vq.push_back(v);
    endtask

    // Behavioural reference model
    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mprev;
    bit         movf, mgerr;
    int         mg[3];

    task automatic model_step(input logic rstn, input logic [2:0] gi, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic rdy);
        logic [2:0] rise;
        bit         multi;
        int         idx;
        ent_t       e;
        if (!rstn) begin
            mq.delete();
            mprev = 3'd0;
            movf  = 0;
            mgerr = 0;
            mg    = '{0, 0, 0};
        end else begin
            rise  = gi & ~mprev;
            multi = $countones(gi) > 1;
            if (multi) mgerr = 1;
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (!multi && $countones(rise) == 1) begin
                idx = rise[0] ? 0 : (rise[1] ? 1 : 2);
                e.d = (idx == 0) ? a : ((idx == 1) ? b : c);
                e.s = 2'(idx);
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                    if (mg[idx] < 65535) mg[idx]++;
                end else begin
                    movf = 1;
                end
            end
            mprev = gi;
        end
    endtask

    task automatic model_check();
        chk("rnd_count", 32'(count), 32'(mq.size()));
        chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("rnd_data", 32'(out_data), 32'(mq[0].d));
            chk("rnd_src",  32'(out_src),  32'(mq[0].s));
        end
        chk("rnd_overflow",  32'(overflow),  32'(movf));
        chk("rnd_grant_err", 32'(grant_err), 32'(mgerr));
`ifdef ARB_GRANT_BUF_STATS_EN
        chk("rnd_gcnt0", 32'(gcnt0), 32'(mg[0]));
        chk("rnd_gcnt1", 32'(gcnt1), 32'(mg[1]));
        chk("rnd_gcnt2", 32'(gcnt2), 32'(mg[2]));
`endif
    endtask

    initial begin
        // reset held with a grant present, then release: one capture only
        for (int i = 0; i < 4; i++)
            addv(0, 3'b001, 8'h11, 8'h22, 8'hA5, 0,  0, 0, 8'h00, 0, 0, 0);
        addv(1, 3'b001, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'h11, 0, 0, 0);
        addv(1, 3'b001, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'h11, 0, 0, 0);
        addv(1, 3'b000, 8'h11, 8'h22, 8'hA5, 1,  0, 0, 8'h00, 0, 0, 0);
        // single grant held three cycles
        addv(1, 3'b100, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'hA5, 2, 0, 0);
        addv(1, 3'b100, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'hA5, 2, 0, 0);
        addv(1, 3'b100, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'hA5, 2, 0, 0);
        addv(1, 3'b000, 8'h11, 8'h22, 8'hA5, 1,  0, 0, 8'h00, 0, 0, 0);
        // direct switch 001 -> 010, then ordered drain
        addv(1, 3'b001, 8'h11, 8'h22, 8'hA5, 0,  1, 1, 8'h11, 0, 0, 0);
        addv(1, 3'b010, 8'h11, 8'h22, 8'hA5, 0,  2, 1, 8'h11, 0, 0, 0);
        addv(1, 3'b000, 8'h11, 8'h22, 8'hA5, 1,  1, 1, 8'h22, 1, 0, 0);
        addv(1, 3'b000, 8'h11, 8'h22, 8'hA5, 1,  0, 0, 8'h00, 0, 0, 0);
        // fill, overflow, then push at full with a simultaneous pop
        addv(1, 3'b001, 8'h31, 8'h32, 8'h33, 0,  1, 1, 8'h31, 0, 0, 0);
        addv(1, 3'b010, 8'h31, 8'h32, 8'h33, 0,  2, 1, 8'h31, 0, 0, 0);
        addv(1, 3'b100, 8'h31, 8'h32, 8'h33, 0,  3, 1, 8'h31, 0, 0, 0);
        addv(1, 3'b001, 8'h31, 8'h32, 8'h33, 0,  4, 1, 8'h31, 0, 0, 0);
        addv(1, 3'b010, 8'h31, 8'h32, 8'h33, 0,  4, 1, 8'h31, 0, 1, 0);
        addv(1, 3'b100, 8'h31, 8'h32, 8'h33, 1,  4, 1, 8'h32, 1, 1, 0);
        // illegal grant (one bit newly rising) and sticky error, then reset
        addv(1, 3'b110, 8'h31, 8'h32, 8'h33, 0,  4, 1, 8'h32, 1, 1, 1);
        addv(1, 3'b000, 8'h31, 8'h32, 8'h33, 0,  4, 1, 8'h32, 1, 1, 1);
        addv(0, 3'b000, 8'h31, 8'h32, 8'h33, 0,  0, 0, 8'h00, 0, 0, 0);

        #1;
        foreach (vq[i]) begin
            resetn = vq[i].rstn; g = vq[i].gv; d0 = vq[i].a; d1 = vq[i].b; d2 = vq[i].c;
            out_ready = vq[i].rdy;
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].vld));
            if (vq[i].vld || !vq[i].rstn) begin
                chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vq[i].dat));
                chk($sformatf("v%0d_src", i),  32'(out_src),  32'(vq[i].src));
            end
            chk($sformatf("v%0d_overflow", i),  32'(overflow),  32'(vq[i].ovf));
            chk($sformatf("v%0d_grant_err", i), 32'(grant_err), 32'(vq[i].gerr));
        end

        // empty push: no same-cycle bypass, valid one cycle later
        resetn = 1; g = 3'b000; out_ready = 0;
        tick();
        g = 3'b001; d0 = 8'h44;
        #1;
        chk("lat_valid_before_edge", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid_after_edge", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h44);
        // queue three entries then reset for one cycle
        g = 3'b010; d1 = 8'h55;
        tick();
        g = 3'b100; d2 = 8'h66;
        tick();
        chk("mid_count3", 32'(count), 32'd3);
        resetn = 0;
        tick();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
`ifdef ARB_GRANT_BUF_STATS_EN
        chk("mid_rst_gcnt0", 32'(gcnt0), 32'd0);
        chk("mid_rst_gcnt1", 32'(gcnt1), 32'd0);
        chk("mid_rst_gcnt2", 32'(gcnt2), 32'd0);
`endif
        resetn = 1;
        tick();
        chk("mid_recapture_count", 32'(count), 32'd1);
        chk("mid_recapture_data", 32'(out_data), 32'h66);
        chk("mid_recapture_src", 32'(out_src), 32'd2);

        // randomized traffic against the model, starting from reset
        resetn = 0; g = 3'b000; out_ready = 0;
        model_step(resetn, g, d0, d1, d2, out_ready);
        tick();
        model_check();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int r;
            resetn = ($urandom_range(0, 79) != 0);
            r = $urandom_range(0, 39);
            if (r < 14)       g = 3'b000;
            else if (r < 39)  g = 3'(1 << $urandom_range(0, 2));
            else              g = 3'(($urandom_range(0, 3) == 0) ? 3'b111 : (3'b011 << $urandom_range(0, 1)));
            if (r == 38) g = 3'b101;
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            out_ready = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            model_step(resetn, g, d0, d1, d2, out_ready);
            tick();
            model_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
